// File: rtl/pc_predict_gen_if.sv
// pc_predict_gen_if: redirect, update and prediction signals of the fetch-PC generator.
// slave is the generator side, master is the ID/front-end side.
interface pc_predict_gen_if #(
    parameter int GHR_W = 8
);
    logic             stall;
    logic             flush;
    logic [31:0]      flush_pc;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [1:0]       upd_kind;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic [GHR_W-1:0] upd_pht_index;
    logic [31:0]      pc_out;
    logic             pc_valid;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [GHR_W-1:0] pred_index;
    modport master (
        output stall, flush, flush_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target, upd_pht_index,
        input  pc_out, pc_valid, pred_taken, pred_target, pred_index
    );
    modport slave (
        input  stall, flush, flush_pc, upd_valid, upd_pc, upd_kind, upd_taken, upd_target, upd_pht_index,
        output pc_out, pc_valid, pred_taken, pred_target, pred_index
    );
endinterface

// File: rtl/pc_predict_gen.sv
// pc_predict_gen: fetch PC generator with gshare PHT, tagged BTB and optional return stack.
// Define PC_PREDICT_RAS_EN to build the return address stack; otherwise returns use the BTB target.
module pc_predict_gen #(
    parameter int          GHR_W     = 8,
    parameter int          BTB_DEPTH = 64,
    parameter int          RAS_DEPTH = 8,
    parameter logic [31:0] INIT_PC   = 32'hbfc00000
) (
    input logic             clk,
    input logic             rst,
    pc_predict_gen_if.slave bus
);
    localparam int BI_W  = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - BI_W;

    if (BTB_DEPTH < 4 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0 || RAS_DEPTH < 1 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_param
        $error("pc_predict_gen: BTB_DEPTH and RAS_DEPTH must be powers of two, BTB_DEPTH >= 4");
    end

    logic [31:0]      r_pc;
    logic             r_valid;
    logic [GHR_W-1:0] r_ghr;
    logic [1:0]       r_pht [2**GHR_W];
    logic [BTB_DEPTH-1:0] r_btb_v;
    logic [TAG_W-1:0] r_btb_tag [BTB_DEPTH];
    logic [31:0]      r_btb_tgt [BTB_DEPTH];
    logic [1:0]       r_btb_kind [BTB_DEPTH];

    logic [BI_W-1:0]  w_idx;
    logic [BI_W-1:0]  w_uidx;
    logic             w_hit;
    logic [1:0]       w_kind;
    logic [GHR_W-1:0] w_pidx;
    logic             w_ptaken;
    logic [31:0]      w_ptgt;
    logic [31:0]      w_next_pc;
    logic             w_spec;
    logic             w_btb_we;
    logic             w_cond_we;
    logic [1:0]       w_pht_old;
    logic [1:0]       w_pht_new;
    logic             w_ras_ne;
    logic [31:0]      w_ras_top;

    assign w_idx     = r_pc[BI_W+1:2];
    assign w_uidx    = bus.upd_pc[BI_W+1:2];
    assign w_hit     = r_btb_v[w_idx] && r_btb_tag[w_idx] == r_pc[31:BI_W+2];
    assign w_kind    = r_btb_kind[w_idx];
    assign w_pidx    = r_pc[GHR_W+1:2] ^ r_ghr;
    assign w_ptaken  = r_valid && w_hit && (w_kind != 2'd0 || r_pht[w_pidx][1]);
    assign w_ptgt    = (w_kind == 2'd3 && w_ras_ne) ? w_ras_top : r_btb_tgt[w_idx];
    assign w_next_pc = bus.flush ? bus.flush_pc : (bus.stall || !r_valid) ? r_pc :
                       w_ptaken ? w_ptgt : r_pc + 32'd4;
    // The RAS only follows predictions that actually steer fetch this edge
    assign w_spec    = !bus.stall && !bus.flush && w_ptaken;
    assign w_btb_we  = bus.upd_valid && (bus.upd_kind != 2'd0 || bus.upd_taken);
    assign w_cond_we = bus.upd_valid && bus.upd_kind == 2'd0;
    assign w_pht_old = r_pht[bus.upd_pht_index];
    assign w_pht_new = bus.upd_taken ? (w_pht_old == 2'b11 ? w_pht_old : w_pht_old + 2'd1) :
                                       (w_pht_old == 2'b00 ? w_pht_old : w_pht_old - 2'd1);

    assign bus.pc_out      = r_pc;
    assign bus.pc_valid    = r_valid;
    assign bus.pred_taken  = w_ptaken;
    assign bus.pred_target = w_ptgt;
    assign bus.pred_index  = w_pidx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= INIT_PC;
            r_valid <= 1'b0;
            r_ghr   <= '0;
            r_btb_v <= '0;
            for (int i = 0; i < 2**GHR_W; i++) r_pht[i] <= 2'b01;
        end else begin
            r_pc    <= w_next_pc;
            r_valid <= r_valid || bus.flush || !bus.stall;
            if (w_btb_we) r_btb_v[w_uidx] <= 1'b1;
            if (w_cond_we) begin
                r_pht[bus.upd_pht_index] <= w_pht_new;
                r_ghr <= {r_ghr[GHR_W-2:0], bus.upd_taken};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_btb_we) begin
            r_btb_tag[w_uidx]  <= bus.upd_pc[31:BI_W+2];
            r_btb_tgt[w_uidx]  <= bus.upd_target;
            r_btb_kind[w_uidx] <= bus.upd_kind;
        end
    end

`ifdef PC_PREDICT_RAS_EN
    localparam int RP_W = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    logic [31:0]   r_ras [RAS_DEPTH];
    logic [RP_W-1:0] r_ras_ptr;
    logic [RP_W:0] r_ras_cnt;
    logic [RP_W-1:0] w_ras_prev;

    assign w_ras_prev = r_ras_ptr - RP_W'(1);
    assign w_ras_ne   = r_ras_cnt != '0;
    assign w_ras_top  = r_ras[w_ras_prev];

    // Circular buffer: pushing when full overwrites the oldest slot, which is the write pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_spec && w_kind == 2'd2) begin
            r_ras[r_ras_ptr] <= r_pc + 32'd8;
            r_ras_ptr <= r_ras_ptr + RP_W'(1);
            r_ras_cnt <= r_ras_cnt == (RP_W+1)'(RAS_DEPTH) ? r_ras_cnt : r_ras_cnt + (RP_W+1)'(1);
        end else if (w_spec && w_kind == 2'd3 && w_ras_ne) begin
            r_ras_ptr <= w_ras_prev;
            r_ras_cnt <= r_ras_cnt - (RP_W+1)'(1);
        end
    end
`else
    assign w_ras_ne  = 1'b0;
    assign w_ras_top = {31'd0, w_spec};
`endif
endmodule

// File: tb/tb_pc_predict_gen.sv
// tb_pc_predict_gen: directed vectors for pc_predict_gen covering advance, stall, PHT, BTB, RAS and flush.
// Return-target expectations follow PC_PREDICT_RAS_EN.
module tb_pc_predict_gen;
    localparam logic [31:0] INIT    = 32'hbfc00000;
    localparam logic [31:0] RET_BTB = 32'hbfc00f00;
    localparam logic [31:0] CALL0   = 32'hbfc01000;
`ifdef PC_PREDICT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    pc_predict_gen_if #(.GHR_W(8)) b ();
    pc_predict_gen #(.GHR_W(8), .BTB_DEPTH(64), .RAS_DEPTH(8), .INIT_PC(INIT)) dut (
        .clk(clk), .rst(rst), .bus(b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [1:0] kind, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic [7:0] idx);
        b.upd_valid = 1'b1;
        b.upd_kind = kind;
        b.upd_pc = pc;
        b.upd_taken = taken;
        b.upd_target = tgt;
        b.upd_pht_index = idx;
        tick();
        b.upd_valid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        b.flush = 1'b1;
        b.flush_pc = pc;
        tick();
        b.flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        b.stall = 1'b0;
        b.flush = 1'b0;
        b.flush_pc = '0;
        b.upd_valid = 1'b0;
        b.upd_pc = '0;
        b.upd_kind = '0;
        b.upd_taken = 1'b0;
        b.upd_target = '0;
        b.upd_pht_index = '0;
        tick();
        tick();
        check("rst_pc", b.pc_out, INIT);
        check("rst_valid", 32'(b.pc_valid), 0);
        check("rst_ptaken", 32'(b.pred_taken), 0);
        rst = 1'b1;
        tick();
        check("c1_pc", b.pc_out, INIT);
        check("c1_valid", 32'(b.pc_valid), 1);
        tick();
        check("c2_pc", b.pc_out, 32'hbfc00004);
        tick();
        check("c3_pc", b.pc_out, 32'hbfc00008);
        b.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", b.pc_out, 32'hbfc00008);
        end
        b.stall = 1'b0;
        tick();
        check("unstall_pc", b.pc_out, 32'hbfc0000c);

        // Two taken updates move counter 7 from 01 to 11 and leave GHR=3
        b.stall = 1'b1;
        upd(2'd0, 32'hbfc00010, 1'b1, 32'hbfc00100, 8'h07);
        upd(2'd0, 32'hbfc00010, 1'b1, 32'hbfc00100, 8'h07);
        b.stall = 1'b0;
        redirect(32'hbfc00010);
        check("cond_pidx", 32'(b.pred_index), 32'h07);
        check("cond_taken", 32'(b.pred_taken), 1);
        check("cond_tgt", b.pred_target, 32'hbfc00100);
        tick();
        check("cond_pc", b.pc_out, 32'hbfc00100);

        // Two not-taken on index 7, then shift GHR back to 3 through an unrelated index
        b.stall = 1'b1;
        upd(2'd0, 32'hbfc00010, 1'b0, 32'hbfc00100, 8'h07);
        upd(2'd0, 32'hbfc00010, 1'b0, 32'hbfc00100, 8'h07);
        for (int i = 0; i < 8; i++) upd(2'd0, 32'hbfc00ff0, i >= 6, 32'hbfc00ff8, 8'haa);
        b.stall = 1'b0;
        redirect(32'hbfc00010);
        check("nt_pidx", 32'(b.pred_index), 32'h07);
        check("nt_taken", 32'(b.pred_taken), 0);
        tick();
        check("nt_pc", b.pc_out, 32'hbfc00014);

        b.stall = 1'b1;
        upd(2'd2, 32'hbfc00020, 1'b0, 32'hbfc00200, 8'h00);
        upd(2'd3, 32'hbfc00204, 1'b0, RET_BTB, 8'h00);
        b.stall = 1'b0;
        redirect(32'hbfc00020);
        check("call_taken", 32'(b.pred_taken), 1);
        check("call_tgt", b.pred_target, 32'hbfc00200);
        tick();
        check("call_pc", b.pc_out, 32'hbfc00200);
        tick();
        check("ret_pc", b.pc_out, 32'hbfc00204);
        check("ret_taken", 32'(b.pred_taken), 1);
        check("ret_tgt", b.pred_target, RAS ? 32'hbfc00028 : RET_BTB);
        tick();
        check("ret_next_pc", b.pc_out, RAS ? 32'hbfc00028 : RET_BTB);

        // Nine calls overflow an 8-deep stack; pops return call sites 8..1
        b.stall = 1'b1;
        for (int i = 0; i < 9; i++) upd(2'd2, CALL0 + 32'(16 * i), 1'b0, 32'hbfc02000, 8'h00);
        b.stall = 1'b0;
        for (int i = 0; i < 9; i++) begin
            redirect(CALL0 + 32'(16 * i));
            tick();
        end
        check("calls_pc", b.pc_out, 32'hbfc02000);
        for (int j = 0; j < 9; j++) begin
            redirect(32'hbfc00204);
            check($sformatf("pop%0d_tgt", j), b.pred_target,
                  (RAS && j < 8) ? CALL0 + 32'(16 * (8 - j)) + 32'd8 : RET_BTB);
            tick();
        end
        check("pops_pc", b.pc_out, RET_BTB);

        redirect(CALL0);
        tick();
        redirect(CALL0 + 32'h30);
        check("fl_taken", 32'(b.pred_taken), 1);
        b.flush = 1'b1;
        b.flush_pc = 32'hbfc00380;
        b.stall = 1'b1;
        tick();
        b.flush = 1'b0;
        b.stall = 1'b0;
        check("fl_pc", b.pc_out, 32'hbfc00380);
        redirect(32'hbfc00204);
        check("fl_ras_top", b.pred_target, RAS ? CALL0 + 32'd8 : RET_BTB);

        rst = 1'b0;
        tick();
        check("rst2_pc", b.pc_out, INIT);
        check("rst2_valid", 32'(b.pc_valid), 0);
        check("rst2_ptaken", 32'(b.pred_taken), 0);
        rst = 1'b1;
        redirect(32'hbfc00204);
        check("rst2_redir_pc", b.pc_out, 32'hbfc00204);
        check("rst2_btb_clear", 32'(b.pred_taken), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pc_predict_gen.md
Name: pc_predict_gen

Overview:
- Parametrised next-generation fetch PC generator for the OOPA front end. Sits ahead of the I-cache and is fed back from ID.
- Predicts the next fetch PC using a gshare PHT, a direct-mapped tagged BTB with a branch-kind field, and an optional return address stack (RAS).
- Handles stall, and redirect on exception or misprediction.
- Generalises the previous PC stage: configurable depths, call/return awareness, saturating 2-bit counters, and an explicit fetch-valid output.

Parameters:
- GHR_W, 8, history bits; PHT has 2^GHR_W 2-bit counters.
- BTB_DEPTH, 64, BTB entries; power of 2, at least 4.
- RAS_DEPTH, 8, RAS entries; power of 2.
- INIT_PC, 32'hbfc00000, reset fetch address.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-low reset.
- stall, input, 1, hold fetch PC.
- flush, input, 1, redirect fetch to flush_pc.
- flush_pc, input, 32, redirect target.
- upd_valid, input, 1, resolved control-flow instruction this cycle.
- upd_pc, input, 32, PC of resolved instruction.
- upd_kind, input, 2, 0=cond, 1=jump, 2=call, 3=return.
- upd_taken, input, 1, resolved direction (cond only).
- upd_target, input, 32, resolved target.
- upd_pht_index, input, GHR_W, PHT index used when predicted.
- pc_out, output, 32, current fetch PC.
- pc_valid, output, 1, pc_out is a real fetch.
- pred_taken, output, 1, predicted redirect for pc_out.
- pred_target, output, 32, predicted next PC when pred_taken.
- pred_index, output, GHR_W, PHT index for pc_out.

Behaviour:
- Reset (rst==0 at clk edge):
  - pc_out=INIT_PC, pc_valid=0.
  - GHR=0; all PHT counters=2'b01; all BTB valid bits=0; RAS count=0, RAS pointer=0.
  - pred_* are combinational, so pred_taken=0 during reset.
- First edge with rst==1 and stall==0: pc_valid<=1 and pc_out stays INIT_PC. Normal advance follows from the next edge.
- Lookup (combinational from pc_out):
  - BTB index = pc_out[log2(BTB_DEPTH)+1:2]; tag = pc_out[31:log2(BTB_DEPTH)+2]; hit = valid and tag match.
  - pred_index = pc_out[GHR_W+1:2] ^ GHR.
  - pred_taken = pc_valid & hit & (kind!=cond | PHT[pred_index][1]).
  - pred_target = RAS top if kind==return and RAS non-empty; otherwise the BTB target.
- Next-PC priority, applied at each edge:
  - flush: pc_out<=flush_pc, pc_valid<=1.
  - else stall: hold pc_out.
  - else pred_taken: pc_out<=pred_target.
  - else pc_out<=pc_out+4; wraps modulo 2^32.
- Update, when upd_valid; occurs regardless of stall or flush:
  - BTB entry at upd_pc index is written: valid, tag, upd_target, upd_kind. Written for cond only if upd_taken; always written for other kinds.
  - Cond only: PHT[upd_pht_index] saturating inc if taken, dec otherwise (00 floor, 11 ceiling); GHR<={GHR[GHR_W-2:0],upd_taken}.
- Same-cycle lookup/update collision on one entry: lookup sees the pre-update value; the write lands at the edge.
- RAS, speculative, acts only on an edge with no stall and no flush, and only when pred_taken:
  - call: push pc_out+8 (return past delay slot). On full, overwrite the oldest entry circularly; count saturates at RAS_DEPTH.
  - return with RAS non-empty: pop; count decrements.
  - return with RAS empty: no pop; BTB target used.
  - flush does not modify the RAS.
- Reset asserted mid-operation discards all predictor state in one cycle.

Optional Feature:
- Macro PC_PREDICT_RAS_EN.
- Defined: RAS present as described above.
- Undefined: no RAS storage; returns predict the BTB target; RAS_DEPTH is unused.

Test Plan:
- Reset, then release with stall=0 → cycle1 pc_out=bfc00000 with pc_valid=1; cycle2 bfc00004; cycle3 bfc00008.
- stall=1 for 3 cycles at pc_out=bfc00008 → pc_out held at bfc00008; deassert → bfc0000c.
- Update cond at upd_pc=bfc00010, taken, target bfc00100, twice with the same index → PHT counter reaches 11. Next fetch of bfc00010 → pred_taken=1 and next pc_out=bfc00100. Two not-taken updates → counter 01 and pred_taken=0.
- Train call at bfc00020 → target bfc00200, and return at bfc00204. Fetch the call → RAS push of bfc00028. Fetch the return → pred_target=bfc00028 with the macro on, or the BTB target with the macro off.
- Nine calls with RAS_DEPTH=8 → count=8 and the oldest entry overwritten; eight returns pop in LIFO order; the ninth return uses the BTB target.
- flush=1 with flush_pc=bfc00380 together with stall=1 and pred_taken=1 → pc_out=bfc00380 and RAS unchanged.
